// File: rtl/em_pipe_stage.sv
// em_pipe_stage: EX/MEM pipeline register with valid/ready handshake,
// synchronous flush, optional 2-entry skid buffer and a qualified
// forwarding strobe for the hazard unit.
module em_pipe_stage #(
    parameter int DATA_W            = 32,
    parameter int PC_W              = 32,
    parameter int INSTR_W           = 32,
    parameter int REG_AW            = 5,
    parameter int SKID              = 1,
    parameter int ZERO_REG_SUPPRESS = 1
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               flush,
    // execute side
    input  logic               e_valid,
    output logic               e_ready,
    input  logic [PC_W-1:0]    e_currPC,
    input  logic [INSTR_W-1:0] e_instruction,
    input  logic               e_writeBack,
    input  logic [REG_AW-1:0]  e_writeReg,
    input  logic [DATA_W-1:0]  e_ALUresult,
    input  logic [DATA_W-1:0]  e_data2,
    // memory side
    output logic               m_valid,
    input  logic               m_ready,
    output logic [PC_W-1:0]    m_currPC,
    output logic [INSTR_W-1:0] m_instruction,
    output logic               m_writeBack,
    output logic [REG_AW-1:0]  m_writeReg,
    output logic [DATA_W-1:0]  m_ALUresult,
    output logic [DATA_W-1:0]  m_data2,
    output logic               m_fwd_en
);

    // One pipeline entry; main register and skid share the same layout.
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               wb;
        logic [REG_AW-1:0]  rg;
        logic [DATA_W-1:0]  alu;
        logic [DATA_W-1:0]  d2;
    } ent_t;

    ent_t w_in;
    ent_t r_main;
    logic w_zero_wr;
    logic w_in_xfer;
    logic w_out_xfer;

    // A write to register 0 is architecturally a no-op, so drop the enable
    // at capture time; downstream never sees a live write to x0.
    assign w_zero_wr = (ZERO_REG_SUPPRESS != 0) && (e_writeReg == '0);

    // Incoming entry assembled from the execute-side fields.
    always_comb begin
        w_in       = '0;
        w_in.pc    = e_currPC;
        w_in.instr = e_instruction;
        w_in.wb    = e_writeBack & ~w_zero_wr;
        w_in.rg    = e_writeReg;
        w_in.alu   = e_ALUresult;
        w_in.d2    = e_data2;
    end

    assign w_in_xfer  = e_valid & e_ready;
    assign w_out_xfer = m_valid & m_ready;

    generate
        if (SKID == 0) begin : g_single
            logic r_valid;

            // Ready passes straight through from the consumer; flush blocks
            // any capture during its cycle.
            assign e_ready = (m_ready | ~r_valid) & ~flush;
            assign m_valid = r_valid;

            // Single entry: valid tracks load/drain, payload only on load.
            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    r_valid <= 1'b0;
                    r_main  <= '0;
                end else begin
                    if (flush)
                        r_valid <= 1'b0;
                    else if (w_in_xfer)
                        r_valid <= 1'b1;
                    else if (w_out_xfer)
                        r_valid <= 1'b0;
                    if (w_in_xfer)
                        r_main <= w_in;
                end
            end
        end else begin : g_skid
            typedef enum logic [1:0] {
                ST_EMPTY = 2'd0,
                ST_ONE   = 2'd1,
                ST_FULL  = 2'd2
            } state_t;

            state_t r_state;
            state_t w_state_nx;
            ent_t   r_skid;
            logic   r_e_rdy;
            logic   w_ld_main;
            logic   w_ld_skid;
            logic   w_main_from_skid;
            logic   w_clr_skid;

            // Ready is registered so the backpressure path is cut; only
            // flush gates it combinationally.
            assign e_ready = r_e_rdy & ~flush;
            assign m_valid = (r_state != ST_EMPTY);

            // Next-state and load controls for the 2-entry FIFO.
            always_comb begin
                w_state_nx       = r_state;
                w_ld_main        = 1'b0;
                w_ld_skid        = 1'b0;
                w_main_from_skid = 1'b0;
                w_clr_skid       = 1'b0;
                if (flush) begin
                    w_state_nx = ST_EMPTY;
                    w_clr_skid = 1'b1;
                end else begin
                    case (r_state)
                        ST_EMPTY: begin
                            if (w_in_xfer) begin
                                w_state_nx = ST_ONE;
                                w_ld_main  = 1'b1;
                            end
                        end
                        ST_ONE: begin
                            if (w_in_xfer && w_out_xfer) begin
                                w_ld_main = 1'b1;
                            end else if (w_in_xfer) begin
                                w_state_nx = ST_FULL;
                                w_ld_skid  = 1'b1;
                            end else if (w_out_xfer) begin
                                w_state_nx = ST_EMPTY;
                            end
                        end
                        ST_FULL: begin
                            // e_ready is low here, so only a drain can happen.
                            if (w_out_xfer) begin
                                w_state_nx       = ST_ONE;
                                w_main_from_skid = 1'b1;
                                w_clr_skid       = 1'b1;
                            end
                        end
                        default: begin
                            w_state_nx = ST_EMPTY;
                        end
                    endcase
                end
            end

            // State register and registered ready.
            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    r_state <= ST_EMPTY;
                    r_e_rdy <= 1'b1;
                end else begin
                    r_state <= w_state_nx;
                    r_e_rdy <= (w_state_nx != ST_FULL);
                end
            end

            // Main payload: fresh input or promoted skid entry.
            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n)
                    r_main <= '0;
                else if (w_ld_main)
                    r_main <= w_in;
                else if (w_main_from_skid)
                    r_main <= r_skid;
            end

            // Skid payload: captures the overflow entry, cleared on promote/flush.
            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n)
                    r_skid <= '0;
                else if (w_ld_skid)
                    r_skid <= w_in;
                else if (w_clr_skid)
                    r_skid <= '0;
            end
        end
    endgenerate

    assign m_currPC      = r_main.pc;
    assign m_instruction = r_main.instr;
    assign m_writeBack   = r_main.wb;
    assign m_writeReg    = r_main.rg;
    assign m_ALUresult   = r_main.alu;
    assign m_data2       = r_main.d2;

    // Forward only a live, real register write.
    assign m_fwd_en = m_valid & m_writeBack & (m_writeReg != '0);

endmodule
